// File: rtl/ring_sched_pkg.sv
// Shared types and helpers for the ring_sched rotating-priority arbiter.
package ring_sched_pkg;

    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Rotate the low n bits of a one-hot right by one; bit 0 wraps to bit n-1.
    function automatic logic [MAX_N-1:0] rotr1(
        input logic [MAX_N-1:0] v,
        input int               n
    );
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) begin
                r[i] = v[0];
            end else if (i < n - 1) begin
                r[i] = v[(i + 1) % MAX_N];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_prio_pick.sv
// Combinational winner search: start at the pointer bit, walk down, wrap N-1.
module ring_prio_pick
    import ring_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    logic [IW-1:0] start;
    logic [IW-1:0] idx;

    always_comb begin
        start = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                start = IW'(i);
            end
        end
    end

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(start) + N - k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/ring_sched.sv
// Rotating-priority arbiter with bounded tenure and a one-cycle release gap.
module ring_sched
    import ring_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid,
    output logic          expired
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          expired_q, expired_d;

    logic [N-1:0]     win;
    logic [IW-1:0]    win_idx;
    logic             any;
    logic [MAX_N-1:0] win_w;
    logic             own_req;

    ring_prio_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign own_req = req[gnt_id_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        expired_d   = 1'b0;
        win_w       = '0;
        win_w[N-1:0] = win;
        unique case (state_q)
            IDLE, GAP: begin
                if (any) begin
                    state_d     = GRANT;
                    gnt_d       = win;
                    gnt_id_d    = win_idx;
                    gnt_valid_d = 1'b1;
                    // Winner drops to lowest priority for the next search.
                    ptr_d       = N'(rotr1(win_w, N));
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!own_req || hold_cnt_q == HOLD_LAST) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    // A voluntary drop wins over an expiring tenure.
                    expired_d   = own_req;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= {1'b1, {(N-1){1'b0}}};
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            expired_q   <= expired_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_ring_sched.sv
// Bench for ring_sched: tenure-level reference model plus directed checks.
module tb_ring_sched;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic          clk;
    logic          rstn;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          gnt_valid;
    logic          expired;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference: who owns the resource, how many cycles it has held it,
    // which index currently has top priority, and whether the last release
    // was forced.
    int m_owner = -1;
    int m_held  = 0;
    int m_top   = N - 1;
    bit m_exp   = 0;

    ring_sched #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_owner = -1;
            m_held  = 0;
            m_top   = N - 1;
            m_exp   = 0;
        end else if (m_owner < 0) begin
            m_exp = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_top - k + N) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_held = 1;
                m_top  = (m_owner + N - 1) % N;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_exp   = 0;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_exp   = 1;
        end else begin
            m_held++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int eg;
            int ei;
            eg = (m_owner >= 0) ? (1 << m_owner) : 0;
            ei = (m_owner >= 0) ? m_owner : 0;
            chk("model_gnt", int'(gnt), eg);
            chk("model_id", int'(gnt_id), ei);
            chk("model_valid", int'(gnt_valid), int'(m_owner >= 0));
            chk("model_expired", int'(expired), int'(m_exp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rstn = 0;
        req  = r;
        step(1);
        rstn = 1;
    endtask

    initial begin
        rstn = 0;
        req  = '0;
        step(2);
        chk_en = 1;
        rstn = 1;
        step(1);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_exp", int'(expired), 0);
        chk("rst_ptr", int'(dut.ptr_q), 'b1000);

        // Single requester, voluntary drop after 3 grant cycles.
        req = 4'b0010;
        step(1);
        chk("single_gnt", int'(gnt), 'b0010);
        chk("single_id", int'(gnt_id), 1);
        step(2);
        chk("single_gnt3", int'(gnt), 'b0010);
        req = 4'b0000;
        step(1);
        chk("single_gap", int'(gnt), 0);
        chk("single_gap_exp", int'(expired), 0);
        step(1);
        chk("single_idle", int'(gnt_valid), 0);

        // Full contention from reset: 3,2,1,0,3 with forced gaps.
        do_reset(4'b1111);
        step(1);
        for (int t = 0; t < 5; t++) begin
            int ids[5] = '{3, 2, 1, 0, 3};
            chk("cont_id", int'(gnt_id), ids[t]);
            step(4);
            chk("cont_gap_gnt", int'(gnt), 0);
            chk("cont_gap_exp", int'(expired), 1);
            step(1);
        end

        // Lone requester held: preempted, then regranted.
        do_reset(4'b0100);
        step(1);
        chk("pre_gnt", int'(gnt), 'b0100);
        step(4);
        chk("pre_exp", int'(expired), 1);
        step(1);
        chk("pre_regnt", int'(gnt), 'b0100);

        // id2 releases; 1001 in the gap must pick id0 (search 1,0).
        req = 4'b1001;
        step(1);
        chk("fair_gap_exp", int'(expired), 0);
        step(1);
        chk("fair_id", int'(gnt_id), 0);
        chk("fair_gnt", int'(gnt), 'b0001);

        // Reset during the second grant cycle.
        step(1);
        rstn = 0;
        req  = 4'b0001;
        step(1);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_ptr", int'(dut.ptr_q), 'b1000);
        chk("midrst_hold", int'(dut.hold_cnt_q), 0);
        rstn = 1;
        step(1);
        chk("midrst_regnt", int'(gnt), 'b0001);

        // Drop on the last allowed cycle: voluntary, not expired.
        step(3);
        req = 4'b0000;
        step(1);
        chk("tie_gap", int'(gnt), 0);
        chk("tie_exp", int'(expired), 0);

        // Others toggling mid-tenure must not disturb it.
        req = 4'b0010;
        step(1);
        req = 4'b1011;
        step(1);
        req = 4'b0110;
        step(1);
        chk("other_id", int'(gnt_id), 1);

        // Free-running mix checked by the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            if (i == 150) rstn = 0;
            if (i == 151) rstn = 1;
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_sched.md
RING_SCHED -- requirements
Module: ring_sched

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesters; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 rstn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  N  SHALL carry the level request per requester, bit i = requester i.
REQ-006 gnt  output  N  SHALL be the registered one-hot grant; all zero when no grant.
REQ-007 gnt_id  output  clog2(N)  SHALL be the registered binary index of the granted requester; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  SHALL be high exactly when gnt is non-zero.
REQ-009 expired  output  1  SHALL be a one-cycle pulse in the dead cycle after a forced release.

Function
REQ-010 The block SHALL keep a one-hot N-bit priority pointer (ptr); exactly one bit is set at all times.
REQ-011 The FSM SHALL have the states IDLE, GRANT and GAP; gnt is non-zero only in GRANT.
REQ-012 In IDLE and GAP, if req is non-zero, the block SHALL enter GRANT at the next edge with the winner.
REQ-013 In IDLE and GAP, if req is all zero, the FSM SHALL go to IDLE (GAP SHALL last exactly one cycle).
REQ-014 Winner search SHALL start at the ptr bit and move to lower indices, wrapping from bit 0 to bit N-1; the first set req bit wins.
REQ-015 On GRANT entry, ptr SHALL load the one-hot of (winner-1) mod N, so the winner has lowest priority next.
REQ-016 Latency SHALL be: req sampled at edge t, gnt/gnt_id/gnt_valid valid after edge t+1.
REQ-017 hold_cnt SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-018 In GRANT, if req[gnt_id] is sampled low, the block SHALL go to GAP at the next edge (voluntary release).
REQ-019 In GRANT, if hold_cnt==MAX_HOLD-1 and req[gnt_id] is still high, the block SHALL go to GAP with expired=1 for that GAP cycle (forced release); gnt is therefore high for at most MAX_HOLD cycles.
REQ-020 When the voluntary and forced conditions are true in the same cycle, the release SHALL be voluntary and expired SHALL stay 0.
REQ-021 Requests from non-granted requesters SHALL not be latched; a request dropped before it is granted is lost.
REQ-022 Requests and deassertions of other requesters during GRANT SHALL not affect the current tenure.
REQ-023 A requester still requesting in GAP SHALL be regranted only if it wins the search from the updated ptr.

Reset
REQ-024 While rstn=0 at an edge, the block SHALL set state=IDLE, ptr=bit N-1 set, hold_cnt=0, gnt=0, gnt_id=0, gnt_valid=0 and expired=0.
REQ-025 Reset SHALL override any state mid-tenure; the first arbitration SHALL happen at the first edge with rstn=1.

Structure
REQ-026 Package ring_sched_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and a rotate-right-by-one function for one-hot vectors.
REQ-027 The combinational winner search SHALL be a sub-module ring_prio_pick (inputs req and ptr; outputs one-hot winner, index and any flag).
REQ-028 All outputs SHALL come directly from flip-flops.

Verification (N=4, MAX_HOLD=4)
REQ-029 Reset: rstn=0 for 2 cycles, then req=0000 -> gnt=0000, gnt_valid=0, expired=0, ptr=1000, FSM stays IDLE.
REQ-030 Single request: req=0010 from edge t, dropped at edge t+3 -> gnt=0010 and gnt_id=1 after edges t+1..t+3; gnt=0000 after t+4 (GAP), then IDLE.
REQ-031 Full contention: req=1111 held -> grants id3, 2, 1, 0, 3, each 4 cycles with expired=1 in each one-cycle gap.
REQ-032 Preempt of one requester: req=0100 held -> gnt=0100 for 4 cycles, one GAP cycle with expired=1, then gnt=0100 again.
REQ-033 Pointer fairness: id2 releases voluntarily and req=1001 in GAP -> next grant is id0 (ptr=0010, search 1,0), expired=0.
REQ-034 Reset mid-tenure: rstn=0 at the 2nd GRANT cycle -> after that edge gnt=0000, ptr=1000, hold_cnt=0; with req=0001 after release, grant id0 one cycle later.
